o_serdes_load_ctrl: RTL and testbench



---
 rtl/o_serdes_pkg.sv | 21 ++
 rtl/o_serdes_sync2.sv | 24 ++
 rtl/o_serdes_load_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_o_serdes_load_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/o_serdes_pkg.sv
// Shared definitions for the O_SERDES word-load sequencer: state encoding,
// load-period helper and counter widths.
package o_serdes_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_WAIT_SYNC = 2'd2,
        ST_RUN       = 2'd3
    } ctrl_state_t;

    localparam int SETTLE_CNT_W  = 10;
    localparam int TIMEOUT_CNT_W = 12;
    localparam int PHASE_W       = 4;

    // Load period in serial-clock cycles: DDR shifts two bits per cycle.
    function automatic int calc_period(input int width, input bit is_ddr);
        return is_ddr ? (width / 2) : width;
    endfunction

endpackage

// File: rtl/o_serdes_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module o_serdes_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/o_serdes_load_ctrl.sv
// Word-load sequencer for bonded O_SERDES lanes: lock settle, sync alignment,
// periodic LOAD_WORD / CHANNEL_BOND_SYNC_OUT. Optional SLIP input: O_SERDES_LOAD_CTRL_SLIP_EN.
module o_serdes_load_ctrl
    import o_serdes_pkg::*;
#(
    parameter     DATA_RATE    = "SDR",
    parameter int WIDTH        = 4,
    parameter int LOCK_WAIT    = 16,
    parameter int SYNC_TIMEOUT = 255
) (
    input  logic       PLL_CLK,
    input  logic       RST,
    input  logic       PLL_LOCK,
    input  logic       CHANNEL_BOND_SYNC_IN,
    input  logic       ENABLE,
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
    input  logic       SLIP,
`endif
    output logic       LOAD_WORD,
    output logic       CHANNEL_BOND_SYNC_OUT,
    output logic [3:0] PHASE,
    output logic       READY,
    output logic       SYNC_ERR
);

    localparam bit IS_DDR = (DATA_RATE == "DDR");
    localparam int P      = calc_period(WIDTH, IS_DDR);

    localparam logic [SETTLE_CNT_W-1:0]  SETTLE_LAST  = SETTLE_CNT_W'(LOCK_WAIT - 1);
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [PHASE_W-1:0]       PHASE_LAST   = PHASE_W'(P - 1);

    generate
        if ((DATA_RATE != "SDR") && (DATA_RATE != "DDR")) begin : g_bad_rate
            $error("o_serdes_load_ctrl: DATA_RATE must be \"SDR\" or \"DDR\"");
        end
        if ((WIDTH < 3) || (WIDTH > 10)) begin : g_bad_width
            $error("o_serdes_load_ctrl: WIDTH must be 3..10");
        end
        if (IS_DDR && ((WIDTH % 2) != 0)) begin : g_odd_ddr
            $error("o_serdes_load_ctrl: DDR requires an even WIDTH");
        end
        if ((LOCK_WAIT < 1) || (LOCK_WAIT > 1023)) begin : g_bad_lock_wait
            $error("o_serdes_load_ctrl: LOCK_WAIT must be 1..1023");
        end
        if ((SYNC_TIMEOUT < 1) || (SYNC_TIMEOUT > 4095)) begin : g_bad_timeout
            $error("o_serdes_load_ctrl: SYNC_TIMEOUT must be 1..4095");
        end
    endgenerate

    // Bit 0: PLL lock, bit 1: channel-bond sync marker.
    logic [1:0] async_in;
    logic [1:0] sync_out;

    assign async_in = {CHANNEL_BOND_SYNC_IN, PLL_LOCK};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            o_serdes_sync2 u_sync2 (
                .clk   (PLL_CLK),
                .rst_n (RST),
                .d     (async_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    logic lock_s;
    logic sync_s;
    logic sync_prev_reg;
    logic sync_edge;
    logic keep_going;

    assign lock_s     = sync_out[0];
    assign sync_s     = sync_out[1];
    assign sync_edge  = sync_s & ~sync_prev_reg;
    assign keep_going = lock_s & ENABLE;

    ctrl_state_t              state_reg,       state_next;
    logic [SETTLE_CNT_W-1:0]  settle_cnt_reg,  settle_cnt_next;
    logic [TIMEOUT_CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic [PHASE_W-1:0]       phase_reg,       phase_next;
    logic                     sync_err_reg,    sync_err_next;
    logic                     load_word_reg,   load_word_next;
    logic                     bond_out_reg,    bond_out_next;
    logic                     ready_reg,       ready_next;
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
    localparam logic [PHASE_W-1:0] SLIP_GUARD_INIT = PHASE_W'(P - 1);
    logic [PHASE_W-1:0]       slip_guard_reg,  slip_guard_next;
`endif

    always_comb begin
        state_next       = state_reg;
        settle_cnt_next  = settle_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        phase_next       = '0;
        sync_err_next    = sync_err_reg;
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
        slip_guard_next  = '0;
`endif
        case (state_reg)
            ST_WAIT_LOCK: begin
                if (keep_going) begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end
            end
            ST_SETTLE: begin
                if (!keep_going) begin
                    state_next = ST_WAIT_LOCK;
                end else if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next       = ST_WAIT_SYNC;
                    timeout_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            ST_WAIT_SYNC: begin
                // A sync edge on the timeout cycle wins: the lane aligned in time.
                if (!keep_going) begin
                    state_next = ST_WAIT_LOCK;
                end else if (sync_edge) begin
                    state_next = ST_RUN;
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    state_next    = ST_RUN;
                    sync_err_next = 1'b1;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (!keep_going) begin
                    state_next = ST_WAIT_LOCK;
                end else begin
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
                    if (slip_guard_reg != '0) begin
                        slip_guard_next = slip_guard_reg - 1'b1;
                    end
`endif
                    if (sync_edge) begin
                        phase_next = '0;
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
                    end else if (SLIP && (slip_guard_reg == '0)) begin
                        phase_next      = phase_reg;
                        slip_guard_next = SLIP_GUARD_INIT;
`endif
                    end else if (phase_reg == PHASE_LAST) begin
                        phase_next = '0;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_WAIT_LOCK;
            end
        endcase

        // Strobes are decoded from the next phase so they register alongside PHASE.
        ready_next     = (state_next == ST_RUN);
        load_word_next = ready_next && (phase_next == PHASE_LAST);
        bond_out_next  = ready_next && (phase_next == '0);
    end

    always_ff @(posedge PLL_CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= ST_WAIT_LOCK;
            settle_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
            phase_reg       <= '0;
            sync_err_reg    <= 1'b0;
            load_word_reg   <= 1'b0;
            bond_out_reg    <= 1'b0;
            ready_reg       <= 1'b0;
            sync_prev_reg   <= 1'b0;
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
            slip_guard_reg  <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            settle_cnt_reg  <= settle_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            phase_reg       <= phase_next;
            sync_err_reg    <= sync_err_next;
            load_word_reg   <= load_word_next;
            bond_out_reg    <= bond_out_next;
            ready_reg       <= ready_next;
            sync_prev_reg   <= sync_s;
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
            slip_guard_reg  <= slip_guard_next;
`endif
        end
    end

    assign LOAD_WORD             = load_word_reg;
    assign CHANNEL_BOND_SYNC_OUT = bond_out_reg;
    assign PHASE                 = phase_reg;
    assign READY                 = ready_reg;
    assign SYNC_ERR              = sync_err_reg;

endmodule

// File: tb/tb_o_serdes_load_ctrl.sv
// Self-checking bench: an SDR/4 lane (long timeout) and a DDR/8 lane (timeout 20)
// share stimulus and are compared every cycle against a timestamp-based reference model.
module tb_o_serdes_load_ctrl;

    logic PLL_CLK = 1'b0;
    logic RST;
    logic PLL_LOCK;
    logic CHANNEL_BOND_SYNC_IN;
    logic ENABLE;
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
    logic SLIP = 1'b0;
`endif

    logic       load_a, bond_a, ready_a, err_a;
    logic [3:0] phase_a;
    logic       load_b, bond_b, ready_b, err_b;
    logic [3:0] phase_b;

    always #5 PLL_CLK = ~PLL_CLK;

    o_serdes_load_ctrl #(
        .DATA_RATE("SDR"), .WIDTH(4), .LOCK_WAIT(16), .SYNC_TIMEOUT(255)
    ) dut_a (
        .PLL_CLK               (PLL_CLK),
        .RST                   (RST),
        .PLL_LOCK              (PLL_LOCK),
        .CHANNEL_BOND_SYNC_IN  (CHANNEL_BOND_SYNC_IN),
        .ENABLE                (ENABLE),
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
        .SLIP                  (SLIP),
`endif
        .LOAD_WORD             (load_a),
        .CHANNEL_BOND_SYNC_OUT (bond_a),
        .PHASE                 (phase_a),
        .READY                 (ready_a),
        .SYNC_ERR              (err_a)
    );

    o_serdes_load_ctrl #(
        .DATA_RATE("DDR"), .WIDTH(8), .LOCK_WAIT(16), .SYNC_TIMEOUT(20)
    ) dut_b (
        .PLL_CLK               (PLL_CLK),
        .RST                   (RST),
        .PLL_LOCK              (PLL_LOCK),
        .CHANNEL_BOND_SYNC_IN  (CHANNEL_BOND_SYNC_IN),
        .ENABLE                (ENABLE),
`ifdef O_SERDES_LOAD_CTRL_SLIP_EN
        .SLIP                  (SLIP),
`endif
        .LOAD_WORD             (load_b),
        .CHANNEL_BOND_SYNC_OUT (bond_b),
        .PHASE                 (phase_b),
        .READY                 (ready_b),
        .SYNC_ERR              (err_b)
    );

    // Reference model: per lane, a mode plus timestamps of the last mode entry
    // and of the last phase-0 anchor. PHASE is (edge - anchor) mod period.
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    logic lock_h [0:8191];
    logic sync_h [0:8191];
    int  m_mode   [2];   // 0 idle, 1 settling, 2 searching, 3 running
    int  m_start  [2];
    int  m_anchor [2];
    bit  m_err    [2];

    function automatic int per_of(input int i);
        return (i == 0) ? 4 : 8 / 2;
    endfunction
    function automatic int wait_of(input int i);
        return (i == 0) ? 16 : 16;
    endfunction
    function automatic int tmo_of(input int i);
        return (i == 0) ? 255 : 20;
    endfunction
    function automatic logic lock_at(input int k);
        return (k < 0) ? 1'b0 : lock_h[k];
    endfunction
    function automatic logic sync_at(input int k);
        return (k < 0) ? 1'b0 : sync_h[k];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_err[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit keep;
        bit sedge;
        lock_h[cyc] = RST ? PLL_LOCK : 1'b0;
        sync_h[cyc] = RST ? CHANNEL_BOND_SYNC_IN : 1'b0;
        keep  = lock_at(cyc - 2) && ENABLE;
        sedge = sync_at(cyc - 2) && !sync_at(cyc - 3);
        if (!RST) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!keep) begin
                    m_mode[i] = 0;
                end else begin
                    case (m_mode[i])
                        0: begin m_mode[i] = 1; m_start[i] = cyc; end
                        1: if (cyc - m_start[i] == wait_of(i)) begin
                               m_mode[i] = 2; m_start[i] = cyc;
                           end
                        2: if (sedge) begin
                               m_mode[i] = 3; m_anchor[i] = cyc;
                           end else if (cyc - m_start[i] == tmo_of(i)) begin
                               m_mode[i] = 3; m_anchor[i] = cyc; m_err[i] = 1'b1;
                           end
                        default: if (sedge) m_anchor[i] = cyc;
                    endcase
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ep;
        bit run;
        for (int i = 0; i < 2; i++) begin
            run = (m_mode[i] == 3);
            ep  = run ? ((cyc - 1 - m_anchor[i]) % per_of(i)) : 0;
            chk($sformatf("lane%0d.PHASE@%0d", i, cyc), (i == 0) ? 8'(phase_a) : 8'(phase_b), 8'(ep));
            chk($sformatf("lane%0d.READY@%0d", i, cyc), (i == 0) ? 8'(ready_a) : 8'(ready_b), 8'(run));
            chk($sformatf("lane%0d.LOAD_WORD@%0d", i, cyc), (i == 0) ? 8'(load_a) : 8'(load_b),
                8'(run && (ep == per_of(i) - 1)));
            chk($sformatf("lane%0d.SYNC_OUT@%0d", i, cyc), (i == 0) ? 8'(bond_a) : 8'(bond_b),
                8'(run && (ep == 0)));
            chk($sformatf("lane%0d.SYNC_ERR@%0d", i, cyc), (i == 0) ? 8'(err_a) : 8'(err_b), 8'(m_err[i]));
        end
    endtask

    task automatic tick(input logic lk, input logic sy, input logic en);
        PLL_LOCK = lk;
        CHANNEL_BOND_SYNC_IN = sy;
        ENABLE = en;
        @(posedge PLL_CLK);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        RST = 1'b0;
        PLL_LOCK = 1'b0;
        CHANNEL_BOND_SYNC_IN = 1'b0;
        ENABLE = 1'b1;
        model_reset();

        // Reset state, then idle with no lock.
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b1);
        RST = 1'b1;
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b1);

        // Lock up: settle, lane b times out, then a sync pulse aligns lane a and realigns b.
        for (int k = 0; k < 45; k++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) tick(1'b1, 1'b0, 1'b1);

        // Random realignment pulses while running.
        for (int k = 0; k < 40; k++) tick(1'b1, 1'($urandom_range(0, 9) == 0), 1'b1);

        // Drop lock at PHASE=2 of lane a, then restore: full settle before any strobe.
        begin
            int k;
            for (k = 0; k < 8 && phase_a != 4'd2; k++) tick(1'b1, 1'b0, 1'b1);
            chk("wait_phase2", 8'(phase_a), 8'd2);
        end
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b1);
        // ENABLE low during settle restarts the wait.
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 1'b1);

        // Randomized lock/enable glitches and sync pulses.
        for (int k = 0; k < 150; k++)
            tick(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 59) != 0));

        // Re-establish RUN on both lanes, then assert reset between clock edges.
        for (int k = 0; k < 24; k++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 1'b1);
        chk("run_before_reset", 8'(ready_a), 8'd1);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b1);
        RST = 1'b1;
        for (int k = 0; k < 50; k++) tick(1'b1, 1'($urandom_range(0, 15) == 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
